// File: rtl/mem_dbus_ctrl.sv
// rtl/mem_dbus_ctrl.sv - MEM-stage load/store controller driving an SRAM-like data bus
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   flush, hold         pipeline flush; downstream (MEM/WB) not advancing
//   ls_op/ls_addr/ls_wdata/except_in
//                       decoded access from EX/MEM (1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW)
//   data_req/wr/size/addr/wdata, data_addr_ok/data_ok/rdata
//                       request/address-ok/data-ok bus transaction
//   stallreq            holds the pipeline while an access is in flight
//   ls_done, load_data  access result (valid only in DONE)
//   adel, ades, bad_vaddr
//                       address-error flags, combinational from the current inputs
//
// Build option: MEM_ALIGN_CHECK_EN
//   defined   - misaligned accesses raise adel/ades and are not issued
//   undefined - flags are tied low and the bus address is aligned down to the access size
module mem_dbus_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          hold,
    input  logic [3:0]    ls_op,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    input  logic          except_in,
    output logic          data_req,
    output logic          data_wr,
    output logic [1:0]    data_size,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata,
    output logic          stallreq,
    output logic          ls_done,
    output logic [DW-1:0] load_data,
    output logic          adel,
    output logic          ades,
    output logic [AW-1:0] bad_vaddr
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t        state, state_nx;
    logic          is_load, is_store;
    logic [1:0]    size;
    logic          align_block;
    logic          access_ok;
    logic          stall;
    logic          data_hit;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] ext_data;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;

    logic [3:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          wr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] load_q;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = 2'd0;
        case (ls_op)
            OP_LB, OP_LBU: begin is_load = 1'b1;  size = 2'd0; end
            OP_LH, OP_LHU: begin is_load = 1'b1;  size = 2'd1; end
            OP_LW:         begin is_load = 1'b1;  size = 2'd2; end
            OP_SB:         begin is_store = 1'b1; size = 2'd0; end
            OP_SH:         begin is_store = 1'b1; size = 2'd1; end
            OP_SW:         begin is_store = 1'b1; size = 2'd2; end
            default:       ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign;
    assign misalign    = (size == 2'd1 && ls_addr[0]) || (size == 2'd2 && ls_addr[1:0] != 2'b00);
    assign align_block = misalign;
    // Gated by reset so the flags read zero while the block is held in reset.
    assign adel        = rst && is_load  && !except_in && misalign;
    assign ades        = rst && is_store && !except_in && misalign;
    assign bad_vaddr   = (adel || ades) ? ls_addr : '0;
    assign req_addr    = ls_addr;
`else
    assign align_block = 1'b0;
    assign adel        = 1'b0;
    assign ades        = 1'b0;
    assign bad_vaddr   = '0;
    // No error path: misaligned addresses are silently aligned down to the access size.
    always_comb begin
        req_addr = ls_addr;
        if (size == 2'd1) begin
            req_addr[0] = 1'b0;
        end else if (size == 2'd2) begin
            req_addr[1:0] = 2'b00;
        end
    end
`endif

    assign access_ok = (is_load || is_store) && !except_in && !align_block;

    // Store data replicated across all lanes so the slave can pick by address.
    always_comb begin
        case (size)
            2'd0:    req_wdata = {4{ls_wdata[7:0]}};
            2'd1:    req_wdata = {2{ls_wdata[15:0]}};
            default: req_wdata = ls_wdata;
        endcase
    end

    // Load extraction uses the registered request; the lane bits that select
    // byte/half are never cleared by the alignment above.
    assign rd_byte = data_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign rd_half = data_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        case (op_q)
            OP_LB:   ext_data = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  ext_data = {24'd0, rd_byte};
            OP_LH:   ext_data = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  ext_data = {16'd0, rd_half};
            OP_LW:   ext_data = data_rdata;
            default: ext_data = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        case (state)
            S_IDLE: begin
                if (access_ok && !flush) begin
                    state_nx = S_REQ;
                    stall    = 1'b1;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (data_addr_ok) begin
                    // Once accepted the access is outstanding; a flush must drain it.
                    if (data_data_ok) begin
                        state_nx = flush ? S_IDLE : S_DONE;
                    end else begin
                        state_nx = flush ? S_DRAIN : S_WAIT;
                    end
                end else if (flush) begin
                    state_nx = S_IDLE;
                end
            end
            S_WAIT: begin
                stall = !data_data_ok;
                if (data_data_ok) begin
                    state_nx = flush ? S_IDLE : S_DONE;
                end else if (flush) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Bus is busy with a killed access; a new one must wait.
                stall = access_ok;
                if (data_data_ok) begin
                    state_nx = S_IDLE;
                end
            end
            S_DONE: begin
                if (flush || !hold) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign data_hit = (state != S_DONE) && (state_nx == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            op_q    <= 4'd0;
            addr_q  <= '0;
            size_q  <= 2'd0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            load_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && state_nx == S_REQ) begin
                op_q    <= ls_op;
                addr_q  <= req_addr;
                size_q  <= size;
                wr_q    <= is_store;
                wdata_q <= req_wdata;
            end
            if (data_hit) begin
                load_q <= ext_data;
            end
        end
    end

    assign data_req   = (state == S_REQ);
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign ls_done    = (state == S_DONE);
    assign load_data  = ls_done ? load_q : '0;
    assign stallreq   = rst && stall;
endmodule
